// File: rtl/mux_seq_pkg.sv
// Shared types and default timing for the break-before-make mux switch sequencer.
package mux_seq_pkg;

  localparam int unsigned CH_W  = 6;
  localparam int unsigned SEL_W = 5;

  // Default phase lengths in 10 ns cycles (ADG1206 enable/address and LT6559 settle).
  localparam int unsigned T_BREAK_DEF  = 2;
  localparam int unsigned T_ADDR_DEF   = 19;
  localparam int unsigned T_SETTLE_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    BREAK,
    ADDR,
    ENABLE,
    SNDON,
    READY
  } seq_state_t;

endpackage

// File: rtl/mux_switch_sequencer_phase_timer.sv
// Loadable down-counter that times one sequencer phase; holds at zero.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk100,
  input  logic             pre_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk100 or posedge pre_reset) begin
    if (pre_reset)          cnt <= '0;
    else if (load)          cnt <= load_value;
    else if (cnt != '0)     cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mux_switch_sequencer.sv
// Break-before-make sequencer for sender enables and ADG1206 P/N mux selects.
module mux_switch_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned N_SND = 32
) (
  input  logic             clk100,
  input  logic             pre_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CH_W-1:0]  req_muxch,
  input  logic [N_SND-1:0] req_en_snd,
  input  logic [SEL_W-1:0] req_mux_p,
  input  logic [SEL_W-1:0] req_mux_n,
  input  logic [CNT_W-1:0] t_break,
  input  logic [CNT_W-1:0] t_addr,
  input  logic [CNT_W-1:0] t_settle,
  input  logic             abort,
  output logic [N_SND-1:0] en_snd,
  output logic [SEL_W-1:0] mux_p,
  output logic [SEL_W-1:0] mux_n,
  output logic             mux_en,
  output logic [CH_W-1:0]  cur_muxch,
  output logic             switching_ready,
  output logic             busy
);

  seq_state_t state, state_d;

  logic [N_SND-1:0] tgt_en_snd;
  logic [SEL_W-1:0] tgt_mux_p, tgt_mux_n;
  logic [CH_W-1:0]  tgt_muxch;
  logic [CNT_W-1:0] t_addr_q, t_settle_q;

  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_value;

  logic             same_c, accept_c;

  logic [N_SND-1:0] en_snd_d;
  logic [SEL_W-1:0] mux_p_d, mux_n_d;
  logic             mux_en_d, switching_ready_d, busy_d;
  logic [CH_W-1:0]  cur_muxch_d;

  // A programmed length of 0 runs the phase for one cycle.
  function automatic logic [CNT_W-1:0] phase_len(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk100     (clk100),
    .pre_reset  (pre_reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  assign req_ready = (state == IDLE) || (state == READY);

  assign same_c = (state == READY) && (req_muxch == cur_muxch) &&
                  (req_en_snd == en_snd) && (req_mux_p == mux_p) &&
                  (req_mux_n == mux_n);

  assign accept_c = req_valid && req_ready && !abort && !same_c;

  always_ff @(posedge clk100 or posedge pre_reset) begin
    if (pre_reset) state <= IDLE;
    else           state <= state_d;
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d           = state;
    tmr_load          = 1'b0;
    tmr_value         = '0;
    en_snd_d          = en_snd;
    mux_p_d           = mux_p;
    mux_n_d           = mux_n;
    mux_en_d          = mux_en;
    cur_muxch_d       = cur_muxch;
    switching_ready_d = switching_ready;
    busy_d            = busy;

    if (abort) begin
      state_d           = IDLE;
      en_snd_d          = '0;
      mux_en_d          = 1'b0;
      switching_ready_d = 1'b0;
      busy_d            = 1'b0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (accept_c) begin
            state_d           = BREAK;
            tmr_load          = 1'b1;
            tmr_value         = phase_len(t_break);
            en_snd_d          = '0;
            mux_en_d          = 1'b0;
            switching_ready_d = 1'b0;
            busy_d            = 1'b1;
          end
        end
        BREAK: begin
          if (tmr_done) begin
            state_d   = ADDR;
            tmr_load  = 1'b1;
            tmr_value = phase_len(t_addr_q);
            mux_p_d   = tgt_mux_p;
            mux_n_d   = tgt_mux_n;
          end
        end
        ADDR: begin
          if (tmr_done) begin
            state_d   = ENABLE;
            tmr_load  = 1'b1;
            tmr_value = phase_len(t_settle_q);
            mux_en_d  = 1'b1;
          end
        end
        ENABLE: begin
          if (tmr_done) begin
            state_d     = SNDON;
            en_snd_d    = tgt_en_snd;
            cur_muxch_d = tgt_muxch;
          end
        end
        SNDON: begin
          state_d           = READY;
          switching_ready_d = 1'b1;
          busy_d            = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk100 or posedge pre_reset) begin
    if (pre_reset) begin
      en_snd          <= '0;
      mux_p           <= '0;
      mux_n           <= '0;
      mux_en          <= 1'b0;
      cur_muxch       <= '0;
      switching_ready <= 1'b0;
      busy            <= 1'b0;
    end else begin
      en_snd          <= en_snd_d;
      mux_p           <= mux_p_d;
      mux_n           <= mux_n_d;
      mux_en          <= mux_en_d;
      cur_muxch       <= cur_muxch_d;
      switching_ready <= switching_ready_d;
      busy            <= busy_d;
    end
  end

  // Targets and timing are captured once per accepted request.
  always_ff @(posedge clk100 or posedge pre_reset) begin
    if (pre_reset) begin
      tgt_en_snd <= '0;
      tgt_mux_p  <= '0;
      tgt_mux_n  <= '0;
      tgt_muxch  <= '0;
      t_addr_q   <= '0;
      t_settle_q <= '0;
    end else if (accept_c) begin
      tgt_en_snd <= req_en_snd;
      tgt_mux_p  <= req_mux_p;
      tgt_mux_n  <= req_mux_n;
      tgt_muxch  <= req_muxch;
      t_addr_q   <= t_addr;
      t_settle_q <= t_settle;
    end
  end

endmodule

// File: tb/tb_mux_switch_sequencer.sv
// Directed bench for mux_switch_sequencer: phase timing, re-switching, abort and reset.
module tb_mux_switch_sequencer;
  import mux_seq_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned N_SND = 32;

  logic             clk100 = 1'b0;
  logic             pre_reset;
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_muxch;
  logic [N_SND-1:0] req_en_snd;
  logic [4:0]       req_mux_p, req_mux_n;
  logic [CNT_W-1:0] t_break, t_addr, t_settle;
  logic             abort;
  logic [N_SND-1:0] en_snd;
  logic [4:0]       mux_p, mux_n;
  logic             mux_en;
  logic [5:0]       cur_muxch;
  logic             switching_ready;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [4:0] prev_p, prev_n;

  mux_switch_sequencer #(.CNT_W(CNT_W), .N_SND(N_SND)) dut (
    .clk100(clk100), .pre_reset(pre_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_muxch(req_muxch),
    .req_en_snd(req_en_snd), .req_mux_p(req_mux_p), .req_mux_n(req_mux_n),
    .t_break(t_break), .t_addr(t_addr), .t_settle(t_settle), .abort(abort),
    .en_snd(en_snd), .mux_p(mux_p), .mux_n(mux_n), .mux_en(mux_en),
    .cur_muxch(cur_muxch), .switching_ready(switching_ready), .busy(busy)
  );

  always #5 clk100 = ~clk100;

  // Safety invariants checked every cycle away from the active edge.
  always @(negedge clk100) begin
    if (!pre_reset) begin
      n_cmp++;
      if (en_snd != '0 && mux_en !== 1'b1) begin
        n_fail++;
        $display("FAIL inv_snd_needs_en: en_snd=%h mux_en=%b", en_snd, mux_en);
      end
      n_cmp++;
      if (mux_en === 1'b1 && {mux_p, mux_n} !== {prev_p, prev_n}) begin
        n_fail++;
        $display("FAIL inv_sel_stable: mux_p/n=%h/%h was %h/%h with mux_en=1", mux_p, mux_n, prev_p, prev_n);
      end
    end
    prev_p = mux_p;
    prev_n = mux_n;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  task automatic set_req(input logic [5:0] ch, input logic [N_SND-1:0] en,
                         input logic [4:0] p, input logic [4:0] n);
    req_muxch  = ch;
    req_en_snd = en;
    req_mux_p  = p;
    req_mux_n  = n;
  endtask

  task automatic test_reset;
    pre_reset = 1'b1; req_valid = 1'b0; abort = 1'b0;
    set_req(6'd0, '0, 5'd0, 5'd0);
    t_break  = CNT_W'(T_BREAK_DEF);
    t_addr   = CNT_W'(T_ADDR_DEF);
    t_settle = CNT_W'(T_SETTLE_DEF);
    step(3);
    n_cmp++;
    if ({en_snd, mux_p, mux_n, mux_en, cur_muxch, switching_ready, busy, req_ready} !==
        {32'h0, 5'h0, 5'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_vals: en=%h p=%h n=%h en=%b ch=%0d rdy=%b busy=%b rr=%b want 0/0/0/0/0/0/0/1",
               en_snd, mux_p, mux_n, mux_en, cur_muxch, switching_ready, busy, req_ready);
    end
    @(negedge clk100);
    pre_reset = 1'b0;
    step(2);
  endtask

  // Channel 5 with default timing; cycle T is the cycle req_valid is presented.
  task automatic test_first_switch;
    set_req(6'd5, 32'h20, 5'h05, 5'h03);
    req_valid = 1'b1;
    step(1);  // T+1
    req_valid = 1'b0;
    n_cmp++;
    if ({busy, mux_en, switching_ready, en_snd, mux_p, req_ready} !== {1'b1, 1'b0, 1'b0, 32'h0, 5'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL t1_break: busy=%b men=%b rdy=%b en=%h p=%h rr=%b want 1/0/0/0/00/0", busy, mux_en, switching_ready, en_snd, mux_p, req_ready);
    end
    step(1);  // T+2
    n_cmp++;
    if (mux_p !== 5'h00) begin n_fail++; $display("FAIL t1_break_hold_p: got %h want 00", mux_p); end
    step(1);  // T+3
    n_cmp++;
    if ({mux_p, mux_n, mux_en} !== {5'h05, 5'h03, 1'b0}) begin
      n_fail++; $display("FAIL t1_addr: p=%h n=%h men=%b want 05/03/0", mux_p, mux_n, mux_en);
    end
    step(18); // T+21
    n_cmp++;
    if (mux_en !== 1'b0) begin n_fail++; $display("FAIL t1_addr_end: mux_en=%b want 0", mux_en); end
    step(1);  // T+22
    n_cmp++;
    if ({mux_en, en_snd} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL t1_enable: men=%b en=%h want 1/0", mux_en, en_snd);
    end
    step(11); // T+33
    n_cmp++;
    if (en_snd !== 32'h0) begin n_fail++; $display("FAIL t1_enable_end: en=%h want 0", en_snd); end
    step(1);  // T+34
    n_cmp++;
    if ({en_snd, cur_muxch, switching_ready, busy} !== {32'h20, 6'd5, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL t1_sndon: en=%h ch=%0d rdy=%b busy=%b want 20/5/0/1", en_snd, cur_muxch, switching_ready, busy);
    end
    step(1);  // T+35
    n_cmp++;
    if ({switching_ready, busy, req_ready} !== 3'b101) begin
      n_fail++; $display("FAIL t1_ready: rdy=%b busy=%b rr=%b want 1/0/1", switching_ready, busy, req_ready);
    end
  endtask

  // Re-switch from READY; timing inputs changed mid-sequence must be ignored.
  task automatic test_reswitch;
    set_req(6'd17, 32'h100, 5'h10, 5'h04);
    req_valid = 1'b1;
    step(1);  // T+1
    req_valid = 1'b0;
    t_addr = 8'd3; t_settle = 8'd3;
    n_cmp++;
    if ({en_snd, mux_en, switching_ready, mux_p} !== {32'h0, 1'b0, 1'b0, 5'h05}) begin
      n_fail++; $display("FAIL t2_break: en=%h men=%b rdy=%b p=%h want 0/0/0/05", en_snd, mux_en, switching_ready, mux_p);
    end
    step(2);  // T+3
    n_cmp++;
    if ({mux_p, mux_n, mux_en} !== {5'h10, 5'h04, 1'b0}) begin
      n_fail++; $display("FAIL t2_addr: p=%h n=%h men=%b want 10/04/0", mux_p, mux_n, mux_en);
    end
    step(18); // T+21
    n_cmp++;
    if (mux_en !== 1'b0) begin n_fail++; $display("FAIL t2_latched_taddr: mux_en=%b want 0", mux_en); end
    step(1);  // T+22
    n_cmp++;
    if (mux_en !== 1'b1) begin n_fail++; $display("FAIL t2_enable: mux_en=%b want 1", mux_en); end
    step(13); // T+35
    n_cmp++;
    if ({switching_ready, cur_muxch, en_snd} !== {1'b1, 6'd17, 32'h100}) begin
      n_fail++; $display("FAIL t2_ready: rdy=%b ch=%0d en=%h want 1/17/100", switching_ready, cur_muxch, en_snd);
    end
    t_addr = CNT_W'(T_ADDR_DEF); t_settle = CNT_W'(T_SETTLE_DEF);
  endtask

  task automatic test_same_channel;
    req_valid = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL t3_ack: req_ready=%b want 1", req_ready); end
    step(1);
    req_valid = 1'b0;
    step(2);
    n_cmp++;
    if ({switching_ready, busy, mux_en, en_snd, mux_p, mux_n, cur_muxch} !==
        {1'b1, 1'b0, 1'b1, 32'h100, 5'h10, 5'h04, 6'd17}) begin
      n_fail++; $display("FAIL t3_no_reseq: rdy=%b busy=%b men=%b en=%h p=%h n=%h ch=%0d want 1/0/1/100/10/04/17",
                         switching_ready, busy, mux_en, en_snd, mux_p, mux_n, cur_muxch);
    end
  endtask

  // req_valid held throughout; a changed request mid-sequence waits for READY.
  task automatic test_back_to_back;
    set_req(6'd9, 32'h200, 5'h09, 5'h19);
    req_valid = 1'b1;
    step(1);  // T+1
    set_req(6'd12, 32'h1000, 5'h0C, 5'h1C);
    n_cmp++;
    if ({req_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL t4_busy: rr=%b busy=%b want 0/1", req_ready, busy); end
    step(9);  // T+10
    n_cmp++;
    if ({req_ready, mux_p} !== {1'b0, 5'h09}) begin
      n_fail++; $display("FAIL t4_ignored: rr=%b p=%h want 0/09", req_ready, mux_p);
    end
    step(25); // T+35
    n_cmp++;
    if ({switching_ready, cur_muxch, en_snd, req_ready} !== {1'b1, 6'd9, 32'h200, 1'b1}) begin
      n_fail++; $display("FAIL t4_first_done: rdy=%b ch=%0d en=%h rr=%b want 1/9/200/1", switching_ready, cur_muxch, en_snd, req_ready);
    end
    step(1);  // T+36, second request accepted at T+35
    req_valid = 1'b0;
    n_cmp++;
    if ({busy, switching_ready, en_snd} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL t4_second_start: busy=%b rdy=%b en=%h want 1/0/0", busy, switching_ready, en_snd);
    end
    step(34); // T+70
    n_cmp++;
    if ({switching_ready, cur_muxch, mux_p, en_snd} !== {1'b1, 6'd12, 5'h0C, 32'h1000}) begin
      n_fail++; $display("FAIL t4_second_done: rdy=%b ch=%0d p=%h en=%h want 1/12/0C/1000", switching_ready, cur_muxch, mux_p, en_snd);
    end
  endtask

  task automatic test_abort;
    set_req(6'd20, 32'h1, 5'h02, 5'h11);
    req_valid = 1'b1;
    step(1);  // T+1
    req_valid = 1'b0;
    step(24); // T+25, in ENABLE
    n_cmp++;
    if ({mux_en, busy} !== 2'b11) begin n_fail++; $display("FAIL t5_in_enable: men=%b busy=%b want 1/1", mux_en, busy); end
    abort = 1'b1;
    set_req(6'd30, 32'h4, 5'h07, 5'h08);
    req_valid = 1'b1;
    step(1);  // T+26
    abort = 1'b0; req_valid = 1'b0;
    n_cmp++;
    if ({busy, mux_en, en_snd, switching_ready, mux_p, mux_n, cur_muxch, req_ready} !==
        {1'b0, 1'b0, 32'h0, 1'b0, 5'h02, 5'h11, 6'd12, 1'b1}) begin
      n_fail++; $display("FAIL t5_abort: busy=%b men=%b en=%h rdy=%b p=%h n=%h ch=%0d rr=%b want 0/0/0/0/02/11/12/1",
                         busy, mux_en, en_snd, switching_ready, mux_p, mux_n, cur_muxch, req_ready);
    end
    step(1);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_not_accepted: busy=%b want 0", busy); end
  endtask

  task automatic test_zero_timing;
    t_break = '0; t_addr = '0; t_settle = '0;
    set_req(6'd3, 32'h8000_0000, 5'h01, 5'h12);
    req_valid = 1'b1;
    step(1);  // T+1
    req_valid = 1'b0;
    n_cmp++;
    if ({busy, mux_en, mux_p} !== {1'b1, 1'b0, 5'h02}) begin
      n_fail++; $display("FAIL t6_break: busy=%b men=%b p=%h want 1/0/02", busy, mux_en, mux_p);
    end
    step(1);  // T+2
    n_cmp++;
    if ({mux_p, mux_n, mux_en} !== {5'h01, 5'h12, 1'b0}) begin
      n_fail++; $display("FAIL t6_addr: p=%h n=%h men=%b want 01/12/0", mux_p, mux_n, mux_en);
    end
    step(1);  // T+3
    n_cmp++;
    if ({mux_en, en_snd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL t6_enable: men=%b en=%h want 1/0", mux_en, en_snd); end
    step(1);  // T+4
    n_cmp++;
    if ({en_snd, switching_ready} !== {32'h8000_0000, 1'b0}) begin
      n_fail++; $display("FAIL t6_sndon: en=%h rdy=%b want 80000000/0", en_snd, switching_ready);
    end
    step(1);  // T+5
    n_cmp++;
    if ({switching_ready, busy, cur_muxch} !== {1'b1, 1'b0, 6'd3}) begin
      n_fail++; $display("FAIL t6_ready: rdy=%b busy=%b ch=%0d want 1/0/3", switching_ready, busy, cur_muxch);
    end
    t_break = CNT_W'(T_BREAK_DEF); t_addr = CNT_W'(T_ADDR_DEF); t_settle = CNT_W'(T_SETTLE_DEF);
  endtask

  task automatic test_async_reset;
    set_req(6'd8, 32'h2, 5'h03, 5'h13);
    req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
    step(25); // inside ENABLE
    #2;
    pre_reset = 1'b1;
    #1;
    n_cmp++;
    if ({en_snd, mux_p, mux_n, mux_en, cur_muxch, switching_ready, busy, req_ready} !==
        {32'h0, 5'h0, 5'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL t7_async_reset: en=%h p=%h n=%h men=%b ch=%0d rdy=%b busy=%b rr=%b want all 0, rr=1",
               en_snd, mux_p, mux_n, mux_en, cur_muxch, switching_ready, busy, req_ready);
    end
    @(negedge clk100);
    pre_reset = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_first_switch();
    test_reswitch();
    test_same_channel();
    test_back_to_back();
    test_abort();
    test_zero_timing();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
